// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared types for the pipeline control slice.
//   reg_idx_t   : 5-bit architectural register index
//   REG_ZERO    : the hard-wired zero register, never a real producer
//   pipe_slot_t : bookkeeping kept for an instruction sitting in p3 or p4
//   SLOT_BUBBLE : an empty slot (no instruction, no write)
package cpu_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic     valid;
    reg_idx_t reg_d;
    logic     wen;
    logic     is_load;
  } pipe_slot_t;

  localparam pipe_slot_t SLOT_BUBBLE = '{valid: 1'b0, reg_d: REG_ZERO, wen: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/cpu_hazard.sv
// cpu_hazard
// Pipeline control sitting just upstream of the p2->p3 operand mux. It keeps
// track of which registers the instructions in p3 and p4 will write, steers
// the p2 operand bypass muxes, stalls p2 on load-use hazards or a busy p3,
// handles branch flushes and owns the p4 register-file write port control.
//
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   p2_valid .. p2_is_load  : decoded description of the instruction in p2
//   p3_busy                 : multi-cycle op in p3 not finished, freeze p2/p3
//   p3_flush                : taken branch resolved in p3, kill p2 instruction
//   p2_bypass_3_a/_b        : take operand A/B from the p3 result
//   p2_bypass_4_a/_b        : take operand A/B from the p4 result
//   p2_stall                : hold p1/p2 this cycle
//   p3_valid                : p3 holds a real instruction
//   p4_reg_d, p4_write_en   : register file write index and enable
//   stall_count             : free-running count of stalled cycles (wraps)
module cpu_hazard
  import cpu_pkg::*;
#(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p2_valid,
  input  logic [4:0]            p2_reg_a,
  input  logic [4:0]            p2_reg_b,
  input  logic                  p2_uses_a,
  input  logic                  p2_uses_b,
  input  logic [4:0]            p2_reg_d,
  input  logic                  p2_write_en,
  input  logic                  p2_is_load,
  input  logic                  p3_busy,
  input  logic                  p3_flush,
  output logic                  p2_bypass_3_a,
  output logic                  p2_bypass_3_b,
  output logic                  p2_bypass_4_a,
  output logic                  p2_bypass_4_b,
  output logic                  p2_stall,
  output logic                  p3_valid,
  output logic [4:0]            p4_reg_d,
  output logic                  p4_write_en,
  output logic [PERF_WIDTH-1:0] stall_count
);

  pipe_slot_t            p3_slot;
  pipe_slot_t            p4_slot;
  logic [PERF_WIDTH-1:0] stall_count_q;

  logic match3_a;
  logic match3_b;
  logic match4_a;
  logic match4_b;
  logic load_hazard;

  // A slot produces a value a p2 operand needs when it holds a real writing
  // instruction whose destination is the operand's register. The zero
  // register is excluded so a write to r0 never forwards or stalls.
  function automatic logic slot_match(input pipe_slot_t slot, input reg_idx_t src, input logic uses);
    return slot.valid & slot.wen & (slot.reg_d == src) & (src != REG_ZERO) & uses;
  endfunction

  // Operand matching, bypass steering and stall generation. p3 is the
  // youngest producer, so a p3 match always shadows a p4 match. A load in p3
  // has no result yet, so it cannot bypass from p3; that case becomes a
  // one-cycle stall after which the load is picked up from p4.
  always_comb begin
    match3_a      = slot_match(p3_slot, p2_reg_a, p2_uses_a);
    match3_b      = slot_match(p3_slot, p2_reg_b, p2_uses_b);
    match4_a      = slot_match(p4_slot, p2_reg_a, p2_uses_a);
    match4_b      = slot_match(p4_slot, p2_reg_b, p2_uses_b);
    load_hazard   = p2_valid & (match3_a | match3_b) & p3_slot.is_load;
    p2_bypass_3_a = match3_a & ~p3_slot.is_load;
    p2_bypass_3_b = match3_b & ~p3_slot.is_load;
    p2_bypass_4_a = match4_a & ~match3_a;
    p2_bypass_4_b = match4_b & ~match3_b;
    p2_stall      = load_hazard | p3_busy;
  end

  // Register-file write control. The write is blocked for r0 and also while
  // reset is asserted, so the instruction sitting in p4 when reset hits never
  // reaches the register file.
  always_comb begin
    p3_valid    = p3_slot.valid;
    p4_reg_d    = p4_slot.reg_d;
    p4_write_en = p4_slot.wen & (p4_slot.reg_d != REG_ZERO) & ~reset;
    stall_count = stall_count_q;
  end

  // Pipeline slot advance. A busy p3 freezes its own slot and sends a bubble
  // into p4 so the frozen instruction is written exactly once, when it
  // finally moves on; a flush raised during busy is ignored because p3 has
  // not resolved yet. Otherwise p3 always drains into p4 and the new p3
  // contents come from p2, unless p2 is being killed by a flush or held by a
  // load-use hazard, in which case a bubble is inserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      p3_slot <= SLOT_BUBBLE;
      p4_slot <= SLOT_BUBBLE;
    end else if (p3_busy) begin
      p4_slot <= SLOT_BUBBLE;
    end else begin
      p4_slot <= '{valid:   p3_slot.valid,
                   reg_d:   p3_slot.reg_d,
                   wen:     p3_slot.wen & p3_slot.valid,
                   is_load: p3_slot.is_load};
      if (p3_flush || load_hazard) begin
        p3_slot <= SLOT_BUBBLE;
      end else begin
        p3_slot <= '{valid:   p2_valid,
                     reg_d:   p2_reg_d,
                     wen:     p2_write_en & p2_valid,
                     is_load: p2_is_load & p2_valid};
      end
    end
  end

  // Performance counter: one tick per stalled cycle, wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (p2_stall) begin
      stall_count_q <= stall_count_q + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cpu_hazard.sv
// tb_cpu_hazard
// Self-checking bench for cpu_hazard. A driver presents one p2 instruction
// per cycle on the falling edge, runs a reference model of the p3/p4
// pipeline and pushes the expected outputs into a scoreboard queue. A
// separate monitor samples the DUT a little after each falling edge, pops
// the expectation and compares field by field.
module tb_cpu_hazard;

  typedef struct {
    bit       valid;
    bit [4:0] ra;
    bit [4:0] rb;
    bit [4:0] rd;
    bit       usesA;
    bit       usesB;
    bit       writes;
    bit       isLoad;
  } instr_t;

  typedef struct {
    bit        b3a;
    bit        b3b;
    bit        b4a;
    bit        b4b;
    bit        stall;
    bit        p3v;
    bit        wen;
    bit [4:0]  rd;
    bit [31:0] count;
  } expect_t;

  logic        clock;
  logic        reset;
  logic        p2_valid;
  logic [4:0]  p2_reg_a;
  logic [4:0]  p2_reg_b;
  logic        p2_uses_a;
  logic        p2_uses_b;
  logic [4:0]  p2_reg_d;
  logic        p2_write_en;
  logic        p2_is_load;
  logic        p3_busy;
  logic        p3_flush;
  logic        p2_bypass_3_a;
  logic        p2_bypass_3_b;
  logic        p2_bypass_4_a;
  logic        p2_bypass_4_b;
  logic        p2_stall;
  logic        p3_valid;
  logic [4:0]  p4_reg_d;
  logic        p4_write_en;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  expect_t scoreboard[$];

  instr_t    inflight[2];
  bit [31:0] modelCount;

  cpu_hazard #(.PERF_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .p2_valid      (p2_valid),
    .p2_reg_a      (p2_reg_a),
    .p2_reg_b      (p2_reg_b),
    .p2_uses_a     (p2_uses_a),
    .p2_uses_b     (p2_uses_b),
    .p2_reg_d      (p2_reg_d),
    .p2_write_en   (p2_write_en),
    .p2_is_load    (p2_is_load),
    .p3_busy       (p3_busy),
    .p3_flush      (p3_flush),
    .p2_bypass_3_a (p2_bypass_3_a),
    .p2_bypass_3_b (p2_bypass_3_b),
    .p2_bypass_4_a (p2_bypass_4_a),
    .p2_bypass_4_b (p2_bypass_4_b),
    .p2_stall      (p2_stall),
    .p3_valid      (p3_valid),
    .p4_reg_d      (p4_reg_d),
    .p4_write_en   (p4_write_en),
    .stall_count   (stall_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Builds an empty pipeline entry.
  function automatic instr_t noInstr();
    instr_t n;
    n.valid  = 1'b0;
    n.ra     = 5'd0;
    n.rb     = 5'd0;
    n.rd     = 5'd0;
    n.usesA  = 1'b0;
    n.usesB  = 1'b0;
    n.writes = 1'b0;
    n.isLoad = 1'b0;
    return n;
  endfunction

  // Builds a real instruction from its fields.
  function automatic instr_t mkInstr(bit [4:0] rd, bit [4:0] ra, bit [4:0] rb,
                                     bit usesA, bit usesB, bit writes, bit isLoad);
    instr_t n;
    n.valid  = 1'b1;
    n.ra     = ra;
    n.rb     = rb;
    n.rd     = rd;
    n.usesA  = usesA;
    n.usesB  = usesB;
    n.writes = writes;
    n.isLoad = isLoad;
    return n;
  endfunction

  // Which in-flight stage holds the youngest older producer of a register:
  // 3 for p3, 4 for p4, 0 when the value comes from the register file.
  function automatic int producerStage(bit [4:0] r, bit uses);
    if (!uses || r == 5'd0) return 0;
    for (int k = 0; k < 2; k++) begin
      if (inflight[k].valid && inflight[k].writes && inflight[k].rd == r) return k + 3;
    end
    return 0;
  endfunction

  // Records one comparison and reports it when it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs the DUT shows during
  // this cycle, queues them and advances the reference pipeline to the
  // state after the next rising edge. consumed reports whether the p2
  // instruction left p2 (issued or discarded) at that edge.
  task automatic applyStimulus(input instr_t ins, input bit busy, input bit flush,
                               input bit rst, output bit consumed);
    expect_t e;
    int      srcA;
    int      srcB;
    bit      loadHaz;
    instr_t  entering;
    @(negedge clock);
    reset       = rst;
    p2_valid    = ins.valid;
    p2_reg_a    = ins.ra;
    p2_reg_b    = ins.rb;
    p2_uses_a   = ins.usesA;
    p2_uses_b   = ins.usesB;
    p2_reg_d    = ins.rd;
    p2_write_en = ins.writes;
    p2_is_load  = ins.isLoad;
    p3_busy     = busy;
    p3_flush    = flush;

    srcA    = producerStage(ins.ra, ins.usesA);
    srcB    = producerStage(ins.rb, ins.usesB);
    loadHaz = ins.valid && (srcA == 3 || srcB == 3) && inflight[0].isLoad;
    e.b3a   = (srcA == 3) && !inflight[0].isLoad;
    e.b3b   = (srcB == 3) && !inflight[0].isLoad;
    e.b4a   = (srcA == 4);
    e.b4b   = (srcB == 4);
    e.stall = loadHaz || busy;
    e.p3v   = inflight[0].valid;
    e.wen   = inflight[1].valid && inflight[1].writes && inflight[1].rd != 5'd0 && !rst;
    e.rd    = inflight[1].rd;
    e.count = modelCount;
    scoreboard.push_back(e);

    if (rst) begin
      inflight[0] = noInstr();
      inflight[1] = noInstr();
      modelCount  = 32'd0;
      consumed    = 1'b1;
    end else begin
      if (e.stall) modelCount = modelCount + 32'd1;
      if (busy) begin
        inflight[1] = noInstr();
        consumed    = 1'b0;
      end else begin
        inflight[1] = inflight[0];
        if (flush) begin
          inflight[0] = noInstr();
          consumed    = 1'b1;
        end else if (loadHaz) begin
          inflight[0] = noInstr();
          consumed    = 1'b0;
        end else begin
          entering        = ins;
          entering.writes = ins.writes && ins.valid;
          entering.isLoad = ins.isLoad && ins.valid;
          if (!ins.valid) entering = noInstr();
          inflight[0] = entering;
          consumed    = 1'b1;
        end
      end
    end
  endtask

  // Presents an instruction until it leaves p2, with a bounded retry count.
  task automatic issueInstr(input instr_t ins);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    while (!done && tries < 8) begin
      applyStimulus(ins, 1'b0, 1'b0, 1'b0, done);
      tries++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL issue_timeout: got stuck after %0d cycles, expected issue", tries);
    end
  endtask

  // A run of empty p2 slots to let the pipeline drain.
  task automatic idle(input int n);
    bit c;
    for (int i = 0; i < n; i++) applyStimulus(noInstr(), 1'b0, 1'b0, 1'b0, c);
  endtask

  // Monitor: shortly after every falling edge, pop one expectation and
  // compare it against the settled DUT outputs.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      #2;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput("bypass_3_a", int'(p2_bypass_3_a), int'(e.b3a));
        checkOutput("bypass_3_b", int'(p2_bypass_3_b), int'(e.b3b));
        checkOutput("bypass_4_a", int'(p2_bypass_4_a), int'(e.b4a));
        checkOutput("bypass_4_b", int'(p2_bypass_4_b), int'(e.b4b));
        checkOutput("p2_stall", int'(p2_stall), int'(e.stall));
        checkOutput("p3_valid", int'(p3_valid), int'(e.p3v));
        checkOutput("p4_write_en", int'(p4_write_en), int'(e.wen));
        if (e.wen) checkOutput("p4_reg_d", int'(p4_reg_d), int'(e.rd));
        checkOutput("stall_count", int'(stall_count), int'(e.count));
      end
    end
  end

  // Directed scenarios first, then a long randomized run with a small
  // register range so dependencies, loads, freezes and flushes collide often.
  initial begin
    bit     c;
    instr_t cur;
    instr_t nop;
    int     drain;
    nop         = noInstr();
    inflight[0] = noInstr();
    inflight[1] = noInstr();
    modelCount  = 32'd0;
    reset       = 1'b1;
    p2_valid    = 1'b0;
    p2_reg_a    = 5'd0;
    p2_reg_b    = 5'd0;
    p2_uses_a   = 1'b0;
    p2_uses_b   = 1'b0;
    p2_reg_d    = 5'd0;
    p2_write_en = 1'b0;
    p2_is_load  = 1'b0;
    p3_busy     = 1'b0;
    p3_flush    = 1'b0;

    applyStimulus(nop, 1'b0, 1'b0, 1'b1, c);
    applyStimulus(nop, 1'b0, 1'b0, 1'b1, c);
    idle(2);

    issueInstr(mkInstr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    issueInstr(mkInstr(5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(3);

    issueInstr(mkInstr(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    issueInstr(mkInstr(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));
    idle(3);

    issueInstr(mkInstr(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    issueInstr(mkInstr(5'd7, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0));
    issueInstr(mkInstr(5'd8, 5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(3);

    issueInstr(mkInstr(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    issueInstr(mkInstr(5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    idle(3);

    issueInstr(mkInstr(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    cur = mkInstr(5'd10, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(cur, 1'b1, 1'b0, 1'b0, c);
    issueInstr(cur);
    idle(3);

    applyStimulus(mkInstr(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0, c);
    idle(3);

    issueInstr(mkInstr(5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    issueInstr(mkInstr(5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0));
    applyStimulus(mkInstr(5'd12, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, c);
    idle(3);

    cur = nop;
    c   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (c) begin
        cur = mkInstr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
        cur.valid = ($urandom_range(0, 7) != 0);
      end
      applyStimulus(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 149) == 0), c);
    end
    idle(2);

    drain = 0;
    while (scoreboard.size() > 0 && drain < 5) begin
      @(negedge clock);
      drain++;
    end
    #5;
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_hazard.md
Name: cpu_hazard

Overview:
- Pipeline control block directly upstream of the p2→p3 operand mux.
- Tracks the destination register of the instructions in p3 and p4.
- Generates the per-operand bypass selects consumed at the end of p2, and detects load-use hazards that require a p2 stall.
- Handles multi-cycle p3 freezes and branch flushes, owns the p4 register-write control (p4_reg_d, p4_write_en), and keeps a stall performance counter.

Parameters:
- PERF_WIDTH, 32, width of stall_count; wraps on overflow.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p2_valid  in  1  p2 holds a real instruction
- p2_reg_a  in  5  source register A index
- p2_reg_b  in  5  source register B index
- p2_uses_a  in  1  instruction reads A
- p2_uses_b  in  1  instruction reads B (0 when literal B)
- p2_reg_d  in  5  destination index
- p2_write_en  in  1  instruction writes p2_reg_d
- p2_is_load  in  1  result only available in p4 (memory load)
- p3_busy  in  1  multi-cycle op in p3 not finished; freeze p2 and p3
- p3_flush  in  1  taken branch resolved in p3; kill p2 instruction
- p2_bypass_3_a / p2_bypass_3_b  out  1 each  select p3 result for operand A / B
- p2_bypass_4_a / p2_bypass_4_b  out  1 each  select p4 result for operand A / B
- p2_stall  out  1  hold p1/p2 this cycle
- p3_valid  out  1  p3 holds a real instruction
- p4_reg_d  out  5  register file write index
- p4_write_en  out  1  register file write enable
- stall_count  out  PERF_WIDTH  cycles with p2_stall=1

Behaviour:
- Internal state:
  - p3 slot: valid, reg_d, wen, is_load.
  - p4 slot: reg_d, wen.
- Match definitions:
  - match3_x = p3_valid & p3_wen & p3_reg_d==p2_reg_x & p2_reg_x!=0 & p2_uses_x.
  - match4_x likewise against the p4 slot.
- Bypass outputs (combinational):
  - bypass_3_x = match3_x & !p3_is_load.
  - bypass_4_x = match4_x & !match3_x. The youngest producer wins; bypass_4 and bypass_3 are never both 1 for the same operand.
- Load-use stall: load_hazard = p2_valid & (match3_a | match3_b) & p3_is_load.
- p2_stall = load_hazard | p3_busy.
- Register r0 never matches, never stalls, and p4_write_en=0 whenever p4_reg_d==0.
- Clock-edge update, priority order:
  - reset: all valid/wen/is_load=0, reg_d=0, stall_count=0; all outputs 0 the cycle after reset asserts.
  - p3_busy=1: p3 slot holds. p4 slot gets a bubble (wen=0) so no double write. p3_flush is ignored while busy.
  - else p3_flush=1: p3 slot becomes a bubble; the p2 instruction is discarded. Current p3 moves to p4 normally.
  - else load_hazard=1: p3 slot becomes a bubble, p2 holds; current p3 moves to p4.
  - else: p3 slot loads from p2 (valid=p2_valid, wen=p2_write_en&p2_valid); p4 loads from p3 (wen=p3_wen&p3_valid).
- stall_count increments on every clock with p2_stall=1 and reset=0.
- Latency:
  - ALU producer to consumer: bypass_3, 0 bubbles.
  - Load to consumer: 1 stall cycle, then bypass_4.
  - Producer two instructions ahead: bypass_4.
  - Producer three ahead: read from the register file. The write and the p2 read happen in the same cycle, and the regfile must return the new value (write-before-read).
- Reset mid-operation discards all in-flight instructions; the p4 write of the reset cycle is suppressed.

Decomposition:
- Package cpu_pkg holds:
  - typedef reg_idx_t (logic [4:0]) and constant REG_ZERO=0.
  - typedef struct pipe_slot_t {valid, reg_d, wen, is_load} for the p3 and p4 slots.
- No sub-module; match logic is a local function.

Test Plan:
- ALU r3 then consumer of r3 on A: p2_bypass_3_a=1 for one cycle, p2_bypass_4_a=0, no stall, stall_count unchanged.
- load r5, then consumer add r6,r5,r5: one cycle p2_stall=1 with both bypass_3 outputs 0. Next cycle p2_bypass_4_a=p2_bypass_4_b=1. stall_count=1.
- Writes to r7 in p4 and in p3, p2 reads r7: only p2_bypass_3_a=1. Producer writing r0 with consumer reading r0: all bypass outputs 0.
- p3_busy held 4 cycles with a dependent instruction in p2: p2_stall=1 for 4 cycles. p4_write_en=0 during the busy period, then exactly one write of the busy instruction's rd. stall_count=+4.
- p3_flush with a writing instruction in p2: next cycle p3_valid=0, and p4_write_en=0 when that slot reaches p4.
- Assert reset with valid writes in p3 and p4: next cycle p4_write_en=0, p3_valid=0, stall_count=0, all bypass outputs 0.
